vga_pixel_fetch: RTL and testbench

Framebuffer fetch engine and pixel FIFO that sits directly upstream of the VGA timing generator. It reads RGB words from the framebuffer memory over a single-outstanding request/acknowledge handshake. Words are buffered in a first-word-fall-through FIFO and presented to the timing generator as `pixel` and `fifo_empty`. One word is popped per active-video cycle. On underflow the block flushes and restarts the frame from the framebuffer base, so raster and data realign.

---
 rtl/vga_pixel_fetch.sv | 109 ++++++++++
 tb/tb_vga_pixel_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch engine with a first-word-fall-through pixel FIFO feeding the VGA timing generator.
// Single outstanding memory read; underflow flushes the FIFO and restarts the frame from FB_BASE.
module vga_pixel_fetch #(
   parameter int unsigned FB_BASE = 0,
   parameter int unsigned NPIX    = 307200,
   parameter int unsigned ADDR_W  = 19,
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned DEPTH   = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              blank,
   output logic              fifo_empty,
   output logic [DATA_W-1:0] pixel,
   output logic [7:0]        underflow_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(FB_BASE);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_BASE + NPIX - 1);
   localparam logic [CNT_W-1:0]  FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

   state_t            state;
   logic [DATA_W-1:0] buffer [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              started;
   logic              pop, push, underflow;
   logic [ADDR_W-1:0] next_addr;

   assign fifo_empty = (count == '0);
   assign pixel      = fifo_empty ? '0 : buffer[rd_ptr];
   assign pop        = blank & ~fifo_empty;
   assign underflow  = blank & fifo_empty & started;
   assign push       = (state == FETCH) & mem_ack & ~underflow;
   assign next_addr  = (mem_addr == LAST) ? BASE : mem_addr + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (push) buffer[wr_ptr] <= mem_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         mem_req       <= 1'b0;
         mem_addr      <= BASE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         started       <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         if (underflow && underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 8'd1;
         if (pop) started <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         unique case (state)
            IDLE: begin
               if (underflow) begin
                  mem_addr <= BASE;
               end else if (count < FULL) begin
                  mem_req <= 1'b1;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  state    <= IDLE;
                  mem_addr <= underflow ? BASE : next_addr;
               end else if (underflow) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  state    <= IDLE;
                  mem_addr <= BASE;
               end
            end
            default: state <= IDLE;
         endcase

         // FIFO is already empty on underflow; clearing started here also keeps a
         // pending FLUSH from counting further underflows before the restart completes.
         if (underflow) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            started <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch: phase table plus a cycle model with a pixel scoreboard.
module tb_vga_pixel_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req, mem_ack = 1'b0, blank = 1'b0;
   logic [18:0] mem_addr;
   logic [23:0] mem_data = '0;
   logic        fifo_empty;
   logic [23:0] pixel;
   logic [7:0]  underflow_cnt;

   logic        req_w, empty_w;
   logic [18:0] addr_w;
   logic [23:0] pixel_w;
   logic [7:0]  ucnt_w;

   always #5 clk = ~clk;

   vga_pixel_fetch dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data), .blank(blank),
      .fifo_empty(fifo_empty), .pixel(pixel), .underflow_cnt(underflow_cnt)
   );

   // Small frame instance with an always-ready memory, for the address wrap sequence.
   vga_pixel_fetch #(.NPIX(4)) dut_w (
      .clk(clk), .rst(rst), .mem_req(req_w), .mem_addr(addr_w),
      .mem_ack(req_w), .mem_data(24'h0), .blank(1'b0),
      .fifo_empty(empty_w), .pixel(pixel_w), .underflow_cnt(ucnt_w)
   );

   logic [18:0] wrap_q[$];
   always @(negedge clk) if (rst && req_w) wrap_q.push_back(addr_w);

   int unsigned total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] data_of(input logic [18:0] a);
      return 24'h112233 + 24'(a);
   endfunction

   // reference model state
   int unsigned m_cnt = 0, n_acks = 0, m_uf_events = 0;
   bit          m_req = 0, m_started = 0, m_flush = 0;
   logic [18:0] m_addr = '0;
   logic [7:0]  m_uf = '0;
   logic [23:0] sb[$];

   task automatic tick(input bit b, input bit ae);
      bit ack, pop, uf, push, nreq;
      ack      = m_req && ae;
      blank    = b;
      mem_ack  = ack;
      mem_data = data_of(mem_addr);
      #1;
      pop  = b && (m_cnt != 0);
      uf   = b && (m_cnt == 0) && m_started;
      push = ack && !m_flush && !uf;
      chk("fifo_empty", fifo_empty, (m_cnt == 0));
      chk("mem_req", mem_req, m_req);
      chk("underflow_cnt", underflow_cnt, m_uf);
      if (m_req) chk("mem_addr", mem_addr, m_addr);
      if (m_cnt == 0) chk("pixel_blank", pixel, 0);
      if (pop) begin
         if (sb.size() == 0) chk("sb_underrun", 0, 1);
         else chk("pixel", pixel, sb.pop_front());
      end
      if (push) sb.push_back(data_of(m_addr));
      nreq = m_req ? !ack : (!uf && m_cnt < 16);
      if (uf) begin
         m_uf = (m_uf == 8'hFF) ? 8'hFF : m_uf + 8'd1;
         m_uf_events++;
         m_cnt = 0;
         m_started = 0;
         sb.delete();
         if (m_req && !ack) m_flush = 1;
         else m_addr = '0;
      end else begin
         m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
         if (pop) m_started = 1;
         if (m_flush && ack) begin
            m_flush = 0;
            m_addr  = '0;
         end
         if (push) m_addr = m_addr + 19'd1;
      end
      m_req = nreq;
      if (ack) n_acks++;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          blank;
      bit          ack_en;
      int unsigned cycles;
      bit          exp_req;
      bit          exp_empty;
      bit          chk_addr;
      logic [18:0] exp_addr;
      int unsigned exp_acks;
      logic [7:0]  exp_uf;
   } row_t;

   row_t rows[12];

   initial begin
      int unsigned guard;
      logic [18:0] wrap_exp [10];

      rows[0]  = '{1'b0, 1'b1, 30, 1'b0, 1'b0, 1'b0, 19'd0,  16, 8'd0}; // fill to 16
      rows[1]  = '{1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b0, 19'd0,  16, 8'd0}; // stays full
      rows[2]  = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b0, 19'd0,  16, 8'd0}; // single pop
      rows[3]  = '{1'b0, 1'b1, 1,  1'b1, 1'b0, 1'b1, 19'd16, 16, 8'd0}; // one request
      rows[4]  = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 19'd0,  17, 8'd0};
      rows[5]  = '{1'b0, 1'b1, 8,  1'b0, 1'b0, 1'b0, 19'd0,  17, 8'd0};
      rows[6]  = '{1'b1, 1'b0, 8,  1'b1, 1'b0, 1'b1, 19'd17, 17, 8'd0}; // drain to 8
      rows[7]  = '{1'b1, 1'b1, 12, 1'b1, 1'b0, 1'b1, 19'd23, 23, 8'd0}; // push+pop
      rows[8]  = '{1'b1, 1'b0, 6,  1'b1, 1'b1, 1'b1, 19'd23, 23, 8'd1}; // underflow
      rows[9]  = '{1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b0, 19'd0,  24, 8'd1}; // flush ack
      rows[10] = '{1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b1, 19'd0,  24, 8'd1}; // restart req
      rows[11] = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 19'd0,  25, 8'd1};

      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_fifo_empty", fifo_empty, 1);
      chk("rst_pixel", pixel, 0);
      chk("rst_underflow_cnt", underflow_cnt, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      tick(1'b0, 1'b1);
      chk("first_req", mem_req, 1);
      chk("first_addr", mem_addr, 0);
      tick(1'b0, 1'b1);
      chk("first_empty", fifo_empty, 0);
      chk("first_pixel", pixel, 24'h112233);

      foreach (rows[r]) begin
         for (int unsigned c = 0; c < rows[r].cycles; c++) tick(rows[r].blank, rows[r].ack_en);
         chk($sformatf("row%0d_req", r), mem_req, rows[r].exp_req);
         chk($sformatf("row%0d_empty", r), fifo_empty, rows[r].exp_empty);
         chk($sformatf("row%0d_acks", r), n_acks, rows[r].exp_acks);
         chk($sformatf("row%0d_ucnt", r), underflow_cnt, rows[r].exp_uf);
         if (rows[r].chk_addr) chk($sformatf("row%0d_addr", r), mem_addr, rows[r].exp_addr);
      end

      guard = 0;
      while (m_uf_events < 301 && guard < 4000) begin
         tick(1'b1, 1'b1);
         guard++;
      end
      chk("sat_budget", (m_uf_events >= 301), 1);
      chk("sat_underflow_cnt", underflow_cnt, 8'hFF);

      for (int i = 0; i < 10; i++) wrap_exp[i] = 19'(i % 4);
      chk("wrap_len", (wrap_q.size() >= 10), 1);
      for (int i = 0; i < 10 && i < wrap_q.size(); i++)
         chk($sformatf("wrap_addr%0d", i), wrap_q[i], wrap_exp[i]);

      guard = 0;
      while (!m_req && guard < 4) begin
         tick(1'b0, 1'b0);
         guard++;
      end
      chk("pre_reset_req", mem_req, 1);
      rst = 1'b0;
      #1;
      chk("async_mem_req", mem_req, 0);
      chk("async_underflow_cnt", underflow_cnt, 0);
      chk("async_fifo_empty", fifo_empty, 1);
      chk("async_mem_addr", mem_addr, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
